// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave endpoint.
// State encodings, default word width and the link mode.
package spi_slave_pkg;

    localparam int SPI_WIDTH = 8;

    // {CPOL, CPHA}; the master uses the same constant
    localparam logic [1:0] SPI_MODE0 = 2'b00;

    typedef enum logic {
        SPI_IDLE  = 1'b0,
        SPI_SHIFT = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with an extra flop for edge detection.
// Brings an asynchronous level into the local clock domain.
module spi_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign level = r_sync;
    assign rise  = r_sync & ~r_prev;
    assign fall  = ~r_sync & r_prev;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: MSB-first receive and transmit of WIDTH-bit
// words, back-to-back while ss stays low, with a TX holding register.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int WIDTH = SPI_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk,
    input  logic             ss,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             tx_underrun,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    spi_state_e       r_state;
    logic [CW-1:0]    r_bit_cnt;
    logic [WIDTH-2:0] r_rx_shift;
    logic [WIDTH-1:0] r_tx_shift;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_rx_valid;
    logic             r_tx_underrun;
    logic             r_frame_err;
    logic [2:0]       r_mosi_d;

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_ss_lvl, w_ss_rise, w_ss_fall;
    logic w_mosi_s;
    logic w_reload;
    logic w_unused;
    logic [WIDTH-1:0] w_next_tx;
    logic [WIDTH-1:0] w_rx_next;

    spi_sync_edge u_sclk (
        .clk   (clk),
        .reset (reset),
        .din   (sclk),
        .level (w_sclk_lvl),
        .rise  (w_sclk_rise),
        .fall  (w_sclk_fall)
    );

    spi_sync_edge u_ss (
        .clk   (clk),
        .reset (reset),
        .din   (ss),
        .level (w_ss_lvl),
        .rise  (w_ss_rise),
        .fall  (w_ss_fall)
    );

    assign w_unused = &{1'b0, w_sclk_lvl, w_ss_lvl};

    // Same depth as the sclk edge path so data lines up with its edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mosi_d <= '0;
        end else begin
            r_mosi_d <= {r_mosi_d[1:0], mosi};
        end
    end

    assign w_mosi_s  = r_mosi_d[2];
    assign w_rx_next = {r_rx_shift, w_mosi_s};
    assign w_next_tx = r_hold_full ? r_hold : '0;

    always_comb begin
        w_reload = 1'b0;
        unique case (r_state)
            SPI_IDLE:  w_reload = w_ss_fall;
            SPI_SHIFT: w_reload = !w_ss_rise && w_sclk_fall &&
                                  (r_bit_cnt == '0);
            default:   w_reload = 1'b0;
        endcase
    end

    // A reload and a load in one cycle: old value leaves, new one lands
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_reload) begin
                r_hold_full <= 1'b0;
            end
            if (tx_load && (!r_hold_full || w_reload)) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= SPI_IDLE;
            r_bit_cnt     <= '0;
            r_rx_shift    <= '0;
            r_tx_shift    <= '0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_frame_err   <= 1'b0;
            unique case (r_state)
                SPI_IDLE: begin
                    if (w_ss_fall) begin
                        r_state       <= SPI_SHIFT;
                        r_tx_shift    <= w_next_tx;
                        r_tx_underrun <= !r_hold_full;
                        r_bit_cnt     <= '0;
                    end
                end
                SPI_SHIFT: begin
                    if (w_ss_rise) begin
                        r_state     <= SPI_IDLE;
                        r_frame_err <= (r_bit_cnt != '0);
                        r_bit_cnt   <= '0;
                        r_tx_shift  <= '0;
                    end else begin
                        if (w_sclk_rise) begin
                            r_rx_shift <= w_rx_next[WIDTH-2:0];
                            if (r_bit_cnt == LAST) begin
                                r_rx_data  <= w_rx_next;
                                r_rx_valid <= 1'b1;
                                r_bit_cnt  <= '0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                        if (w_sclk_fall) begin
                            if (r_bit_cnt == '0) begin
                                r_tx_shift    <= w_next_tx;
                                r_tx_underrun <= !r_hold_full;
                            end else begin
                                r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
                            end
                        end
                    end
                end
                default: r_state <= SPI_IDLE;
            endcase
        end
    end

    assign miso        = r_tx_shift[WIDTH-1];
    assign tx_ready    = !r_hold_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_underrun = r_tx_underrun;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a behavioural mode-0 master drives frames
// and every received/transmitted byte is checked against a model.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sclk = 1'b0;
    logic       ss = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       frame_err;

    int total = 0;
    int bad = 0;

    logic [7:0] rxq[$];
    int n_und = 0;
    int n_fe = 0;
    int n_wide = 0;
    logic pv_rx = 1'b0, pv_un = 1'b0, pv_fe = 1'b0;

    spi_slave #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .sclk        (sclk),
        .ss          (ss),
        .mosi        (mosi),
        .miso        (miso),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    // Pulse monitor: logs received bytes, counts pulses and wide pulses
    always @(negedge clk) begin
        if (!reset) begin
            pv_rx = 1'b0;
            pv_un = 1'b0;
            pv_fe = 1'b0;
        end else begin
            if (rx_valid) rxq.push_back(rx_data);
            if (tx_underrun) n_und++;
            if (frame_err) n_fe++;
            if ((rx_valid && pv_rx) || (tx_underrun && pv_un) ||
                (frame_err && pv_fe)) n_wide++;
            pv_rx = rx_valid;
            pv_un = tx_underrun;
            pv_fe = frame_err;
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        rxq.delete();
        n_und = 0;
        n_fe = 0;
    endtask

    task automatic load(input logic [7:0] v);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic frame_begin();
        ss = 1'b0;
        wait_n(4);
    endtask

    task automatic frame_end();
        wait_n(4);
        ss = 1'b1;
        wait_n(6);
    endtask

    // Mode-0 master: mosi set while sclk low, miso sampled at the rise.
    // Optionally pulses tx_load after the first rise; rdy is tx_ready
    // one cycle after that pulse.
    task automatic send_byte(input logic [7:0] b, input int nbits,
                             input bit do_load, input logic [7:0] lv,
                             output logic [7:0] got, output logic rdy);
        got = 8'h00;
        rdy = 1'bx;
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            wait_n(4);
            got[7-i] = miso;
            sclk = 1'b1;
            if (i == 0 && do_load) begin
                load(lv);
                rdy = tx_ready;
                wait_n(3);
            end else begin
                wait_n(4);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic test_reset();
        total++;
        if (miso !== 1'b0) begin
            bad++; $display("FAIL reset_miso got=%b exp=0", miso);
        end
        total++;
        if (rx_data !== 8'h00) begin
            bad++; $display("FAIL reset_rx_data got=%h exp=00", rx_data);
        end
        total++;
        if (rx_valid !== 1'b0) begin
            bad++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid);
        end
        total++;
        if (tx_ready !== 1'b1) begin
            bad++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready);
        end
        total++;
        if (tx_underrun !== 1'b0) begin
            bad++; $display("FAIL reset_underrun got=%b exp=0", tx_underrun);
        end
        total++;
        if (frame_err !== 1'b0) begin
            bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err);
        end
    endtask

    task automatic test_single();
        logic [7:0] got;
        logic rdy;
        load(8'hA5);
        total++;
        if (tx_ready !== 1'b0) begin
            bad++; $display("FAIL single_ready_after_load got=%b exp=0", tx_ready);
        end
        clr();
        frame_begin();
        send_byte(8'h3C, 8, 1'b0, 8'h00, got, rdy);
        frame_end();
        total++;
        if (got !== 8'hA5) begin
            bad++; $display("FAIL single_miso got=%h exp=a5", got);
        end
        total++;
        if (rxq.size() != 1 || rxq[0] !== 8'h3C) begin
            bad++; $display("FAIL single_rx n=%0d exp 1 byte 3c", rxq.size());
        end
        total++;
        if (n_fe != 0) begin
            bad++; $display("FAIL single_frame_err got=%0d exp=0", n_fe);
        end
        // only the trailing boundary reload finds the holding register empty
        total++;
        if (n_und != 1) begin
            bad++; $display("FAIL single_underrun got=%0d exp=1", n_und);
        end
        total++;
        if (tx_ready !== 1'b1) begin
            bad++; $display("FAIL single_ready_end got=%b exp=1", tx_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] g1, g2;
        logic r1, r2;
        load(8'h81);
        clr();
        frame_begin();
        send_byte(8'h11, 8, 1'b1, 8'h7E, g1, r1);
        send_byte(8'h22, 8, 1'b0, 8'h00, g2, r2);
        frame_end();
        total++;
        if (r1 !== 1'b0) begin
            bad++; $display("FAIL b2b_ready_after_load got=%b exp=0", r1);
        end
        total++;
        if (g1 !== 8'h81 || g2 !== 8'h7E) begin
            bad++; $display("FAIL b2b_miso got=%h,%h exp=81,7e", g1, g2);
        end
        total++;
        if (rxq.size() != 2 || rxq[0] !== 8'h11 || rxq[1] !== 8'h22) begin
            bad++; $display("FAIL b2b_rx n=%0d exp 11,22", rxq.size());
        end
        total++;
        if (n_und != 1) begin
            bad++; $display("FAIL b2b_underrun got=%0d exp=1", n_und);
        end
    endtask

    task automatic test_underrun();
        logic [7:0] got;
        logic rdy;
        clr();
        frame_begin();
        total++;
        if (n_und != 1) begin
            bad++; $display("FAIL underrun_at_ss_fall got=%0d exp=1", n_und);
        end
        send_byte(8'h96, 8, 1'b0, 8'h00, got, rdy);
        frame_end();
        total++;
        if (got !== 8'h00) begin
            bad++; $display("FAIL underrun_miso got=%h exp=00", got);
        end
        total++;
        if (rxq.size() != 1 || rxq[0] !== 8'h96) begin
            bad++; $display("FAIL underrun_rx n=%0d exp 1 byte 96", rxq.size());
        end
        total++;
        if (n_und != 2) begin
            bad++; $display("FAIL underrun_count got=%0d exp=2", n_und);
        end
    endtask

    task automatic test_frame_err();
        logic [7:0] got, prev;
        logic rdy;
        prev = rx_data;
        clr();
        frame_begin();
        send_byte(8'hC3, 5, 1'b0, 8'h00, got, rdy);
        frame_end();
        total++;
        if (n_fe != 1) begin
            bad++; $display("FAIL ferr_pulse got=%0d exp=1", n_fe);
        end
        total++;
        if (rxq.size() != 0) begin
            bad++; $display("FAIL ferr_no_valid got=%0d exp=0", rxq.size());
        end
        total++;
        if (rx_data !== prev) begin
            bad++; $display("FAIL ferr_rx_hold got=%h exp=%h", rx_data, prev);
        end
        clr();
        frame_begin();
        send_byte(8'hF0, 8, 1'b0, 8'h00, got, rdy);
        frame_end();
        total++;
        if (rxq.size() != 1 || rxq[0] !== 8'hF0 || n_fe != 0) begin
            bad++; $display("FAIL ferr_next_frame n=%0d fe=%0d exp 1 byte f0 fe 0",
                            rxq.size(), n_fe);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        logic rdy;
        load(8'h44);
        frame_begin();
        send_byte(8'hE7, 3, 1'b0, 8'h00, got, rdy);
        reset = 1'b0;
        #1;
        test_reset();
        ss = 1'b1;
        sclk = 1'b0;
        wait_n(3);
        reset = 1'b1;
        wait_n(6);
        load(8'h69);
        clr();
        frame_begin();
        send_byte(8'h5A, 8, 1'b0, 8'h00, got, rdy);
        frame_end();
        total++;
        if (rxq.size() != 1 || rxq[0] !== 8'h5A) begin
            bad++; $display("FAIL rstmid_rx n=%0d exp 1 byte 5a", rxq.size());
        end
        total++;
        if (got !== 8'h69) begin
            bad++; $display("FAIL rstmid_miso got=%h exp=69", got);
        end
    endtask

    task automatic test_ignored_load();
        logic [7:0] got;
        logic rdy;
        load(8'h12);
        load(8'h34);
        load(8'h34);
        total++;
        if (tx_ready !== 1'b0) begin
            bad++; $display("FAIL ignload_ready got=%b exp=0", tx_ready);
        end
        clr();
        frame_begin();
        send_byte(8'hB2, 8, 1'b0, 8'h00, got, rdy);
        frame_end();
        total++;
        if (got !== 8'h12) begin
            bad++; $display("FAIL ignload_miso got=%h exp=12", got);
        end
        total++;
        if (n_und != 1) begin
            bad++; $display("FAIL ignload_underrun got=%0d exp=1", n_und);
        end
    endtask

    // Model: byte k goes out as its loaded value or 0x00; one underrun per
    // unloaded byte plus one for the reload after the last byte.
    task automatic test_random();
        logic [7:0] rx_b[3];
        logic [7:0] ld_v[3];
        bit         ld_e[3];
        logic [7:0] got[3];
        logic       rdy;
        logic [7:0] exp_tx;
        int nb, exp_und;
        for (int f = 0; f < 8; f++) begin
            nb = $urandom_range(1, 3);
            exp_und = 1;
            for (int k = 0; k < 3; k++) begin
                rx_b[k] = 8'($urandom);
                ld_v[k] = 8'($urandom);
                ld_e[k] = 1'($urandom_range(0, 1));
                if (k < nb && !ld_e[k]) exp_und++;
            end
            if (ld_e[0]) load(ld_v[0]);
            clr();
            frame_begin();
            for (int k = 0; k < nb; k++) begin
                send_byte(rx_b[k], 8, (k + 1 < nb) && ld_e[k+1],
                          ld_v[(k + 1) % 3], got[k], rdy);
            end
            frame_end();
            for (int k = 0; k < nb; k++) begin
                exp_tx = ld_e[k] ? ld_v[k] : 8'h00;
                total++;
                if (got[k] !== exp_tx) begin
                    bad++; $display("FAIL rand_miso f=%0d k=%0d got=%h exp=%h",
                                    f, k, got[k], exp_tx);
                end
                total++;
                if (rxq.size() <= k || rxq[k] !== rx_b[k]) begin
                    bad++; $display("FAIL rand_rx f=%0d k=%0d n=%0d exp=%h",
                                    f, k, rxq.size(), rx_b[k]);
                end
            end
            total++;
            if (rxq.size() != nb) begin
                bad++; $display("FAIL rand_rx_count f=%0d got=%0d exp=%0d",
                                f, rxq.size(), nb);
            end
            total++;
            if (n_und != exp_und || n_fe != 0) begin
                bad++; $display("FAIL rand_pulses f=%0d und=%0d exp=%0d fe=%0d exp=0",
                                f, n_und, exp_und, n_fe);
            end
        end
    endtask

    initial begin
        wait_n(3);
        test_reset();
        reset = 1'b1;
        wait_n(4);
        test_single();
        test_back_to_back();
        test_underrun();
        test_frame_err();
        test_reset_mid();
        test_ignored_load();
        test_random();
        total++;
        if (n_wide != 0) begin
            bad++; $display("FAIL pulse_width wide=%0d exp=0", n_wide);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
